if_fetch_unit: RTL and testbench

//  Instruction-fetch producer. Generates the PC, runs the request/ack handshake to instruction memory
//  (cache or SRAM, variable latency), and holds one fetched instruction for the IF/ID pipeline register.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_stall_counter.sv | 30 +++
 rtl/if_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } if_state_e;

    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] INSN_NOP = 32'h0;

endpackage

// File: rtl/if_stall_counter.sv
// Saturating event counter for fetch stall cycles (used when IF_PERF_CNT_EN is defined).
module if_stall_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: PC generation, imem req/ack handshake, one-entry IF/ID slot.
// Optional stall-cycle counter enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc_out,
    output logic [31:0]      instruction_out,
`ifdef IF_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
`endif
    output logic             valid_out
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic        kill_q, kill_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        accept, slot_free;

    assign accept    = valid_q & ~freeze;
    assign slot_free = ~valid_q | accept;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        kill_addr_d = kill_addr_q;
        hold_d      = hold_q;
        insn_d      = insn_q;
        pc_out_d    = pc_out_q;
        valid_d     = accept ? 1'b0 : valid_q;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else if (!branch_taken) begin
                        if (slot_free) begin
                            insn_d   = imem_rdata;
                            pc_out_d = pc_q + PC_INC;
                            valid_d  = 1'b1;
                            pc_d     = pc_q + PC_INC;
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    insn_d   = hold_q;
                    pc_out_d = pc_q + PC_INC;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + PC_INC;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over everything; an unacked request finishes at its old address.
        if (branch_taken) begin
            pc_d    = {branch_addr[31:2], 2'b00};
            valid_d = 1'b0;
            hold_d  = INSN_NOP;
            if (state_q == S_HOLD) begin
                state_d = S_REQ;
            end
            if ((state_q == S_REQ) && !imem_ack && !kill_q) begin
                kill_d      = 1'b1;
                kill_addr_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            kill_addr_q <= '0;
            hold_q      <= INSN_NOP;
            insn_q      <= INSN_NOP;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            kill_addr_q <= kill_addr_d;
            hold_q      <= hold_d;
            insn_q      <= insn_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
        end
    end

    assign imem_req        = (state_q == S_REQ);
    assign imem_addr       = imem_req ? (kill_q ? kill_addr_q : pc_q) : 32'h0;
    assign pc_out          = pc_out_q;
    assign instruction_out = insn_q;
    assign valid_out       = valid_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^branch_addr[1:0];

`ifdef IF_PERF_CNT_EN
    if_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   ((imem_req & ~imem_ack) | (valid_q & freeze)),
        .count (stall_cycles)
    );
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a variable-latency memory model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    // Second instance exercises the PC wrap from RESET_PC = 32'hFFFFFFFC.
    logic        w_freeze;
    logic        w_branch;
    logic [31:0] w_branch_addr;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_pc_out;
    logic [31:0] w_insn;
    logic        w_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] w_stall_cycles;
`endif

    logic [31:0] lat;
    logic        ack_force;
    logic [31:0] wcnt;
    int          checks;
    int          errors;

    if_fetch_unit #(
        .RESET_PC (32'h0),
        .CNT_W    (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
`ifdef IF_PERF_CNT_EN
        .stall_cycles    (stall_cycles),
`endif
        .valid_out       (valid_out)
    );

    if_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .CNT_W    (32)
    ) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .freeze          (w_freeze),
        .branch_taken    (w_branch),
        .branch_addr     (w_branch_addr),
        .imem_req        (w_req),
        .imem_addr       (w_addr),
        .imem_ack        (w_ack),
        .imem_rdata      (w_rdata),
        .pc_out          (w_pc_out),
        .instruction_out (w_insn),
`ifdef IF_PERF_CNT_EN
        .stall_cycles    (w_stall_cycles),
`endif
        .valid_out       (w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after 'lat' waiting cycles; data is the inverted address.
    assign imem_ack   = ack_force | (imem_req & (wcnt >= lat));
    assign imem_rdata = ~imem_addr;
    assign w_ack      = w_req;
    assign w_rdata    = 32'h1234_5678;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= 32'd0;
        end else begin
            wcnt <= (imem_req && !imem_ack) ? wcnt + 32'd1 : 32'd0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] e;
        checks        = 0;
        errors        = 0;
        freeze        = 1'b0;
        branch_taken  = 1'b0;
        branch_addr   = 32'h0;
        w_freeze      = 1'b0;
        w_branch      = 1'b0;
        w_branch_addr = 32'h0;
        ack_force     = 1'b0;
        lat           = 32'd0;
        rst           = 1'b0;
        #2;
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("rst_pc_out", pc_out, 32'h0);
        check_eq("rst_insn", instruction_out, 32'h0);
`ifdef IF_PERF_CNT_EN
        check_eq("rst_stall", stall_cycles, 32'd0);
`endif

        // Zero-wait memory streams one instruction per cycle.
        do_reset();
        step();
        check_eq("zw_first_req", {31'd0, imem_req}, 32'd1);
        check_eq("zw_first_addr", imem_addr, 32'h0);
        check_eq("zw_first_valid", {31'd0, valid_out}, 32'd0);
        for (int n = 1; n <= 5; n++) begin
            step();
            e = 32'(4 * n);
            check_eq("zw_valid", {31'd0, valid_out}, 32'd1);
            check_eq("zw_pc_out", pc_out, e);
            check_eq("zw_insn", instruction_out, ~(e - 32'd4));
            check_eq("zw_addr", imem_addr, e);
            if (n == 1) begin
                check_eq("wrap_pc_out", w_pc_out, 32'h0);
                check_eq("wrap_addr", w_addr, 32'h0);
                check_eq("wrap_valid", {31'd0, w_valid}, 32'd1);
                check_eq("wrap_insn", w_insn, 32'h1234_5678);
            end
        end

        // Freeze: one word parks in the hold buffer, no new request.
        freeze = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check_eq("frz_req", {31'd0, imem_req}, 32'd0);
            check_eq("frz_pc_out", pc_out, 32'd20);
            check_eq("frz_valid", {31'd0, valid_out}, 32'd1);
        end
        freeze = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            step();
            e = 32'(20 + 4 * n);
            check_eq("rel_pc_out", pc_out, e);
            check_eq("rel_insn", instruction_out, ~(e - 32'd4));
            check_eq("rel_valid", {31'd0, valid_out}, 32'd1);
        end

        // Branch while holding, with freeze still asserted.
        freeze = 1'b1;
        step();
        check_eq("hold_req", {31'd0, imem_req}, 32'd0);
        check_eq("hold_pc_out", pc_out, 32'd32);
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        step();
        branch_taken = 1'b0;
        freeze       = 1'b0;
        check_eq("hbr_valid", {31'd0, valid_out}, 32'd0);
        check_eq("hbr_req", {31'd0, imem_req}, 32'd1);
        check_eq("hbr_addr", imem_addr, 32'h200);
        step();
        check_eq("hbr_pc_out", pc_out, 32'h204);
        check_eq("hbr_insn", instruction_out, ~32'h200);

        // Three wait states: address held four cycles, one word every four cycles.
        lat = 32'd3;
        do_reset();
        step();
        check_eq("lat_first_addr", imem_addr, 32'h0);
        for (int n = 1; n <= 16; n++) begin
            step();
            e = 32'(4 * (n / 4));
            check_eq("lat_req", {31'd0, imem_req}, 32'd1);
            check_eq("lat_addr", imem_addr, e);
            check_eq("lat_valid", {31'd0, valid_out}, (n % 4 == 0) ? 32'd1 : 32'd0);
            if (n % 4 == 0) begin
                check_eq("lat_pc_out", pc_out, e);
                check_eq("lat_insn", instruction_out, ~(e - 32'd4));
            end
        end
`ifdef IF_PERF_CNT_EN
        check_eq("stall_cnt", stall_cycles, 32'd12);
`endif

        // Asynchronous reset mid-request, then an ack that must be ignored.
        #1;
        rst = 1'b0;
        #1;
        check_eq("arst_req", {31'd0, imem_req}, 32'd0);
        check_eq("arst_addr", imem_addr, 32'h0);
        check_eq("arst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("arst_pc_out", pc_out, 32'h0);
        check_eq("arst_insn", instruction_out, 32'h0);
`ifdef IF_PERF_CNT_EN
        check_eq("arst_stall", stall_cycles, 32'd0);
`endif
        ack_force = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        ack_force = 1'b0;
        check_eq("late_ack_valid", {31'd0, valid_out}, 32'd0);
        check_eq("late_ack_addr", imem_addr, 32'h0);
        step();
        check_eq("late_ack_valid2", {31'd0, valid_out}, 32'd0);

        // Redirects against an outstanding request and against a same-cycle ack.
        lat = 32'd3;
        do_reset();
        step();
        check_eq("br0_addr", imem_addr, 32'h0);
        branch_taken = 1'b1;
        branch_addr  = 32'h20;
        step();
        branch_taken = 1'b0;
        check_eq("kill_addr_a", imem_addr, 32'h0);
        step();
        check_eq("kill_addr_b", imem_addr, 32'h0);
        step();
        check_eq("kill_addr_c", imem_addr, 32'h0);
        step();
        check_eq("br0_target", imem_addr, 32'h20);
        check_eq("br0_valid", {31'd0, valid_out}, 32'd0);
        step();
        check_eq("br1_addr_a", imem_addr, 32'h20);
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        step();
        branch_taken = 1'b0;
        check_eq("br1_addr_b", imem_addr, 32'h20);
        step();
        check_eq("br1_addr_c", imem_addr, 32'h20);
        step();
        check_eq("br1_target", imem_addr, 32'h100);
        check_eq("br1_drop_valid", {31'd0, valid_out}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("br1_wait_valid", {31'd0, valid_out}, 32'd0);
        end
        step();
        check_eq("br1_valid", {31'd0, valid_out}, 32'd1);
        check_eq("br1_pc_out", pc_out, 32'h104);
        check_eq("br1_insn", instruction_out, ~32'h100);
        branch_taken = 1'b1;
        branch_addr  = 32'h103;
        step();
        branch_taken = 1'b0;
        check_eq("br2_valid", {31'd0, valid_out}, 32'd0);
        check_eq("br2_old_addr", imem_addr, 32'h104);
        step();
        step();
        step();
        check_eq("br2_align", imem_addr, 32'h100);
        lat          = 32'd0;
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        step();
        branch_taken = 1'b0;
        check_eq("br3_addr", imem_addr, 32'h40);
        check_eq("br3_valid", {31'd0, valid_out}, 32'd0);
        step();
        check_eq("br3_pc_out", pc_out, 32'h44);
        check_eq("br3_insn", instruction_out, ~32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
